// File: rtl/local_flit_injector.sv
// Packet-to-flit injector for a router local port: one header flit then body flits,
// each flit gated by a per-VC credit counter that the router replenishes.
module local_flit_injector #(
    parameter int V     = 2,
    parameter int B     = 4,
    parameter int DAw   = 8,
    parameter int SIZEw = 6,
    parameter int Fpay  = 32,
    localparam int Vw   = (V > 1) ? $clog2(V) : 1,
    localparam int Fw   = Fpay + V + 2,
    localparam int HDw  = Fpay - DAw - SIZEw
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pck_valid,
    output logic             pck_ready,
    input  logic [Vw-1:0]    pck_vc,
    input  logic [DAw-1:0]   pck_dest,
    input  logic [SIZEw-1:0] pck_size,
    input  logic [HDw-1:0]   pck_hdr_data,
    input  logic [Fpay-1:0]  data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [Fw-1:0]    flit_out,
    output logic             flit_out_wr,
    input  logic [V-1:0]     credit_in,
    output logic             busy,
    output logic             credit_err
);

    localparam int Cw = $clog2(B + 1);
    localparam logic [SIZEw-1:0] SZ_ONE   = SIZEw'(1);
    localparam logic [Cw-1:0]    CNT_FULL = Cw'(B);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [Vw-1:0]    r_vc;
    logic [DAw-1:0]   r_dest;
    logic [SIZEw-1:0] r_size;
    logic [SIZEw-1:0] r_rem;
    logic [HDw-1:0]   r_hdr_data;
    logic [Cw-1:0]    r_cnt [V];

    logic             w_has_credit;
    logic             w_send;
    logic             w_hdr;
    logic             w_tail;
    logic [Fpay-1:0]  w_payload;
    logic [V-1:0]     w_vc_oh;
    logic [V-1:0]     w_dec;
    logic [V-1:0]     w_full;
    logic             w_err_set;

    assign w_has_credit = (r_cnt[r_vc] != '0);
    assign w_err_set    = |(credit_in & ~w_dec & w_full);

    // Next-state, send decision and handshake outputs for the packet FSM
    always_comb begin
        w_state_nxt = r_state;
        w_send      = 1'b0;
        w_hdr       = 1'b0;
        w_tail      = 1'b0;
        w_payload   = '0;
        pck_ready   = 1'b0;
        data_ready  = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                pck_ready = 1'b1;
                busy      = 1'b0;
                if (pck_valid) begin
                    w_state_nxt = S_HDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HDR: begin
                if (w_has_credit) begin
                    w_send      = 1'b1;
                    w_hdr       = 1'b1;
                    w_payload   = {r_hdr_data, r_size, r_dest};
                    w_tail      = (r_size == SZ_ONE);
                    w_state_nxt = (r_size == SZ_ONE) ? S_IDLE : S_BODY;
                end else begin
                    w_state_nxt = S_HDR;
                end
            end
            S_BODY: begin
                data_ready = w_has_credit;
                if (data_valid && w_has_credit) begin
                    w_send      = 1'b1;
                    w_payload   = data_in;
                    w_tail      = (r_rem == SZ_ONE);
                    w_state_nxt = (r_rem == SZ_ONE) ? S_IDLE : S_BODY;
                end else begin
                    w_state_nxt = S_BODY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One-hot VC field and per-VC decrement / full vectors for the credit counters
    always_comb begin
        w_vc_oh        = '0;
        w_vc_oh[r_vc]  = 1'b1;
        w_dec          = '0;
        w_full         = '0;
        for (int v = 0; v < V; v++) begin
            w_dec[v]  = w_send && (r_vc == Vw'(v));
            w_full[v] = (r_cnt[v] == CNT_FULL);
        end
    end

    // FSM state, descriptor latch, remaining-flit count and registered flit output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_vc        <= '0;
            r_dest      <= '0;
            r_size      <= '0;
            r_hdr_data  <= '0;
            r_rem       <= '0;
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (pck_valid && pck_ready) begin
                r_vc       <= pck_vc;
                r_dest     <= pck_dest;
                r_size     <= (pck_size == '0) ? SZ_ONE : pck_size;
                r_hdr_data <= pck_hdr_data;
            end else begin
                r_vc       <= r_vc;
                r_dest     <= r_dest;
                r_size     <= r_size;
                r_hdr_data <= r_hdr_data;
            end
            if (w_send) begin
                flit_out    <= {w_hdr, w_tail, w_vc_oh, w_payload};
                flit_out_wr <= 1'b1;
                r_rem       <= w_hdr ? (r_size - SZ_ONE) : (r_rem - SZ_ONE);
            end else begin
                flit_out    <= '0;
                flit_out_wr <= 1'b0;
                r_rem       <= r_rem;
            end
        end
    end

    // Credit counters: +1 per returned credit, -1 per flit sent; overflow is held and flagged
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                r_cnt[v] <= CNT_FULL;
            end
            credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < V; v++) begin
                case ({credit_in[v], w_dec[v]})
                    2'b10:   r_cnt[v] <= w_full[v] ? r_cnt[v] : r_cnt[v] + Cw'(1);
                    2'b01:   r_cnt[v] <= r_cnt[v] - Cw'(1);
                    default: r_cnt[v] <= r_cnt[v];
                endcase
            end
            if (w_err_set) begin
                credit_err <= 1'b1;
            end else begin
                credit_err <= credit_err;
            end
        end
    end

endmodule

// File: tb/tb_local_flit_injector.sv
// Scoreboard bench for local_flit_injector: expected flits are queued at packet issue,
// a monitor checks every output cycle, and a router model tracks outstanding flits per VC.
module tb_local_flit_injector;

    localparam int V     = 2;
    localparam int B     = 4;
    localparam int DAw   = 8;
    localparam int SIZEw = 6;
    localparam int Fpay  = 32;
    localparam int Fw    = Fpay + V + 2;
    localparam int HDw   = Fpay - DAw - SIZEw;

    logic             clk          = 1'b0;
    logic             reset        = 1'b1;
    logic             pck_valid    = 1'b0;
    logic             pck_ready;
    logic [0:0]       pck_vc       = 1'b0;
    logic [DAw-1:0]   pck_dest     = '0;
    logic [SIZEw-1:0] pck_size     = '0;
    logic [HDw-1:0]   pck_hdr_data = '0;
    logic [Fpay-1:0]  data_in      = '0;
    logic             data_valid   = 1'b0;
    logic             data_ready;
    logic [Fw-1:0]    flit_out;
    logic             flit_out_wr;
    logic [V-1:0]     credit_in    = '0;
    logic             busy;
    logic             credit_err;

    int              n_tests  = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    logic            fire_d   = 1'b0;
    logic            fire_p   = 1'b0;
    logic            last_rst = 1'b1;
    logic [V-1:0]    last_cred = '0;
    logic [Fw-1:0]   exp_q[$];
    logic [Fpay-1:0] data_q[$];
    int              wr_log[$];
    int              o [V] = '{default: 0};
    logic            exp_err  = 1'b0;
    int              cur_vc   = 0;
    int              dv_mode  = 0;
    logic            dv_tog   = 1'b0;
    logic            cred_rand = 1'b0;
    logic [V-1:0]    cred_force = '0;

    local_flit_injector #(.V(V), .B(B), .DAw(DAw), .SIZEw(SIZEw), .Fpay(Fpay)) dut (
        .clk(clk), .reset(reset), .pck_valid(pck_valid), .pck_ready(pck_ready),
        .pck_vc(pck_vc), .pck_dest(pck_dest), .pck_size(pck_size),
        .pck_hdr_data(pck_hdr_data), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
        .credit_in(credit_in), .busy(busy), .credit_err(credit_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Capture what happened at each rising edge (pre-edge handshake values)
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        fire_d    <= data_valid & data_ready;
        fire_p    <= pck_valid & pck_ready;
        last_cred <= credit_in;
        last_rst  <= reset;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int log_at(input int i);
        return (i >= 0 && i < wr_log.size()) ? wr_log[i] : -1;
    endfunction

    // Monitor: scoreboard pop, router credit model, reset and handshake checks
    initial begin
        logic [Fw-1:0] e;
        int ev;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (last_rst) begin
                exp_q.delete();
                for (int v = 0; v < V; v++) o[v] = 0;
                exp_err = 1'b0;
                chk("rst_wr", 64'(flit_out_wr), 64'(0));
                chk("rst_flit", 64'(flit_out), 64'(0));
                chk("rst_pck_ready", 64'(pck_ready), 64'(1));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_data_ready", 64'(data_ready), 64'(0));
                chk("rst_credit_err", 64'(credit_err), 64'(0));
            end else begin
                if (flit_out_wr) begin
                    chk("flit_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("flit", 64'(flit_out), 64'(e));
                        ev = e[Fpay+1] ? 1 : 0;
                        chk("credit_avail", 64'(o[ev] < B), 64'(1));
                        o[ev]++;
                    end
                    wr_log.push_back(cyc);
                end else begin
                    chk("idle_flit_zero", 64'(flit_out), 64'(0));
                end
                for (int v = 0; v < V; v++) begin
                    if (last_cred[v]) begin
                        if (o[v] > 0) o[v]--;
                        else exp_err = 1'b1;
                    end
                end
                chk("credit_err", 64'(credit_err), 64'(exp_err));
                chk("ready_vs_busy", 64'(pck_ready), 64'(!busy));
                if (data_ready) chk("data_ready_credit", 64'(o[cur_vc] < B), 64'(1));
            end
        end
    end

    // Body data source
    initial begin
        logic [Fpay-1:0] junk;
        logic want;
        forever begin
            @(negedge clk); #2;
            if (last_rst) data_q.delete();
            else if (fire_d && data_q.size() > 0) junk = data_q.pop_front();
            case (dv_mode)
                0:       want = 1'b1;
                1:       begin dv_tog = ~dv_tog; want = dv_tog; end
                default: want = 1'($urandom_range(0, 1));
            endcase
            data_valid = want && (data_q.size() > 0);
            data_in    = (data_q.size() > 0) ? data_q[0] : $urandom;
        end
    end

    // Router credit return: forced pulses plus random returns of outstanding flits
    initial begin
        logic [V-1:0] rc;
        forever begin
            @(negedge clk); #2;
            for (int v = 0; v < V; v++)
                rc[v] = cred_rand && (o[v] > 0) && ($urandom_range(0, 2) == 0);
            credit_in = cred_force | rc;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic send_pkt(input int vc, input int dest, input int sz, output int acc);
        int eff;
        logic [HDw-1:0] hd;
        logic [V-1:0] oh;
        logic [Fpay-1:0] w;
        logic got;
        eff = (sz == 0) ? 1 : sz;
        hd  = HDw'($urandom);
        oh  = '0;
        oh[vc] = 1'b1;
        exp_q.push_back({1'b1, 1'(eff == 1), oh, hd, SIZEw'(eff), DAw'(dest)});
        for (int i = 1; i < eff; i++) begin
            w = $urandom;
            data_q.push_back(w);
            exp_q.push_back({1'b0, 1'(i == eff - 1), oh, w});
        end
        pck_vc       = 1'(vc);
        pck_dest     = DAw'(dest);
        pck_size     = SIZEw'(sz);
        pck_hdr_data = hd;
        pck_valid    = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            tick();
            got = fire_p;
        end
        pck_valid = 1'b0;
        acc    = cyc;
        cur_vc = vc;
        chk("accept", 64'(got), 64'(1));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !pck_ready) && k < 3000) begin
            tick();
            k++;
        end
        chk("packet_done", 64'(k < 3000), 64'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            for (int v = 0; v < V; v++) cred_force[v] = (o[v] > 0);
            tick();
        end
        cred_force = '0;
        tick();
    endtask

    // Directed scenarios followed by a randomized phase
    initial begin
        int acc;
        int n;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("idle_ready", 64'(pck_ready), 64'(1));
        chk("idle_no_flits", 64'(wr_log.size()), 64'(0));

        // single-flit packet on vc1
        send_pkt(1, 8'h23, 1, acc);
        wait_done();
        chk("single_count", 64'(wr_log.size()), 64'(1));
        chk("single_latency", 64'(log_at(0)), 64'(acc + 1));
        drain();

        // size 0 is treated as one flit
        wr_log.delete();
        send_pkt(0, 8'h11, 0, acc);
        wait_done();
        chk("size0_count", 64'(wr_log.size()), 64'(1));
        drain();

        // six-flit packet, no credit return: four flits then a stall
        wr_log.delete();
        send_pkt(0, 8'h44, 6, acc);
        repeat (8) tick();
        chk("starve_count", 64'(wr_log.size()), 64'(4));
        chk("starve_first", 64'(log_at(0)), 64'(acc + 1));
        chk("starve_last", 64'(log_at(3)), 64'(acc + 4));
        n = cyc;
        cred_force = 2'b01;
        tick();
        cred_force = 2'b01;
        tick();
        cred_force = '0;
        wait_done();
        chk("resume_count", 64'(wr_log.size()), 64'(6));
        chk("resume_first", 64'(log_at(4)), 64'(n + 2));
        chk("resume_second", 64'(log_at(5)), 64'(n + 3));
        drain();

        // credit returned to a full counter
        cred_force = 2'b10;
        tick();
        cred_force = '0;
        repeat (3) tick();
        chk("credit_err_sticky", 64'(credit_err), 64'(1));

        // data_valid toggling during the body
        dv_mode   = 1;
        cred_rand = 1'b1;
        wr_log.delete();
        send_pkt(1, 8'h5a, 5, acc);
        wait_done();
        chk("toggle_count", 64'(wr_log.size()), 64'(5));
        cred_rand = 1'b0;
        drain();

        // reset in the middle of a size-8 body, then a fresh packet with full credits
        dv_mode = 0;
        send_pkt(0, 8'h80, 8, acc);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_rst_ready", 64'(pck_ready), 64'(1));
        chk("post_rst_wr", 64'(flit_out_wr), 64'(0));
        tick();
        tick();
        wr_log.delete();
        send_pkt(0, 8'h81, 4, acc);
        wait_done();
        chk("post_rst_count", 64'(wr_log.size()), 64'(4));
        chk("post_rst_burst", 64'(log_at(3)), 64'(acc + 4));
        drain();

        // randomized traffic
        dv_mode   = 2;
        cred_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 12), acc);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_done();
        cred_rand = 1'b0;
        drain();
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
